simon_out_sched: RTL

//   Output scheduler for the SIMON packetiser (SIMON_dataOUT).

---
 rtl/simon_out_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/simon_out_sched.sv
// SIMON dataOUT output scheduler: round-robin core/status arbitration, one packet in flight at a time.
// Grant to doneDATA takes 1 edge; requests wait (unacknowledged) until the current packet is released or dropped.
module simon_out_sched #(
    parameter int N       = 16,
    parameter int TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               nR,
    input  logic               validCORE,
    input  logic [1:0][N-1:0]  dataCORE,
    input  logic [7:0]         infoCORE,
    output logic               readCORE,
    input  logic               validSTAT,
    input  logic [7:0]         infoSTAT,
    output logic               readSTAT,
    output logic               doneDATA,
    output logic [7:0]         infoOUT,
    output logic [7:0]         countOUT,
    output logic [1:0][N-1:0]  outDATA,
    input  logic               readDATA,
    input  logic               donePKT,
    input  logic               readPKT,
    output logic               busy,
    output logic               errOUT
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_WAIT_PKT  = 3'd2;
    localparam logic [2:0] S_WAIT_HOST = 3'd3;
    localparam logic [2:0] S_RELEASE   = 3'd4;

    localparam int             WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]         r_state;
    logic [WDW-1:0]     r_wdog;
    logic               r_last_core;
    logic               r_read_core;
    logic               r_read_stat;
    logic               r_done;
    logic [7:0]         r_info;
    logic [7:0]         r_count;
    logic [1:0][N-1:0]  r_data;
    logic               r_err;

    logic               w_req;
    logic               w_grant_stat;
    logic               w_wd_exp;

    assign w_req        = validCORE | validSTAT;
    // On a tie the requester that was not served last wins.
    assign w_grant_stat = validSTAT & (~validCORE | r_last_core);
    assign w_wd_exp     = (TIMEOUT != 0) && (r_wdog == WD_LAST);

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            r_state     <= S_IDLE;
            r_wdog      <= '0;
            r_last_core <= 1'b1;
            r_read_core <= 1'b0;
            r_read_stat <= 1'b0;
            r_done      <= 1'b0;
            r_info      <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_read_core <= 1'b0;
            r_read_stat <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_done      <= 1'b1;
                        r_wdog      <= '0;
                        r_last_core <= ~w_grant_stat;
                        r_state     <= S_LOAD;
                        if (w_grant_stat) begin
                            r_read_stat <= 1'b1;
                            r_data      <= '0;
                            r_info      <= infoSTAT;
                        end else begin
                            r_read_core <= 1'b1;
                            r_data      <= dataCORE;
                            r_info      <= infoCORE;
                        end
                    end
                end
                S_LOAD: begin
                    // readDATA takes priority over a watchdog expiry on the same edge.
                    if (readDATA) begin
                        r_done  <= 1'b0;
                        r_wdog  <= '0;
                        r_state <= S_WAIT_PKT;
                    end else if (w_wd_exp) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wdog  <= r_wdog + 1'b1;
                    end
                end
                S_WAIT_PKT: begin
                    if (donePKT) begin
                        r_state <= S_WAIT_HOST;
                    end else if (w_wd_exp) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wdog  <= r_wdog + 1'b1;
                    end
                end
                S_WAIT_HOST: begin
                    if (readPKT) begin
                        r_count <= r_count + 8'd1;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!readPKT && !donePKT) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign readCORE = r_read_core;
    assign readSTAT = r_read_stat;
    assign doneDATA = r_done;
    assign infoOUT  = r_info;
    assign countOUT = r_count;
    assign outDATA  = r_data;
    assign errOUT   = r_err;
    assign busy     = (r_state != S_IDLE);

endmodule
